// File: rtl/ro_sample_counter.sv
// Ring-oscillator sample counter: counts synchronized RO rising edges per window and emits their sum.
// Define RO_CNT_SAT_EN for saturating per-RO counters (saturated window reads back as all ones).
module ro_sample_counter #(
  parameter int unsigned NUM_RO = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SUM_W  = CNT_W + $clog2(NUM_RO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ro_rst,
  input  logic              ro_en,
  input  logic              valid_in,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [SUM_W-1:0]  sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned IdxW = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_RO - 1);

  typedef enum logic [1:0] {StIdle, StCount, StSum} state_e;

  state_e            state_q;
  logic [NUM_RO-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_RO-1:0] ro_edge;
  logic [CNT_W-1:0]  cnt_q   [NUM_RO];
  logic [CNT_W-1:0]  cnt_nxt [NUM_RO];
  logic [SUM_W-1:0]  acc_q;
  logic [SUM_W-1:0]  acc_sum;
  logic [IdxW-1:0]   idx_q;
  logic              load_q;
  logic [SUM_W-1:0]  sample_data_q;
  logic              sample_valid_q;
  logic              overrun_q;
  logic              busy_q;
`ifdef RO_CNT_SAT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  logic sat_q;
  logic sat_hit;
`endif

  assign ro_edge = sync2_q & ~sync3_q;

  always_comb begin
`ifdef RO_CNT_SAT_EN
    sat_hit = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (ro_en && ro_edge[i]) begin
`ifdef RO_CNT_SAT_EN
        if (cnt_q[i] == CntMax) begin
          sat_hit = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        end
`else
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
`endif
      end
    end
  end

  always_comb begin
    acc_sum = acc_q + SUM_W'(cnt_q[idx_q]);
`ifdef RO_CNT_SAT_EN
    if (sat_q) begin
      acc_sum = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sync1_q        <= '0;
      sync2_q        <= '0;
      sync3_q        <= '0;
      cnt_q          <= '{default: '0};
      acc_q          <= '0;
      idx_q          <= '0;
      load_q         <= 1'b0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
`ifdef RO_CNT_SAT_EN
      sat_q          <= 1'b0;
`endif
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      load_q  <= 1'b0;

      // Consumption first so a same-cycle reload below takes precedence.
      if (sample_valid_q && sample_ready) begin
        sample_valid_q <= 1'b0;
      end
      if (load_q) begin
        if (!sample_valid_q || sample_ready) begin
          sample_data_q  <= acc_q;
          sample_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      if (ro_rst) begin
        state_q <= StIdle;
        cnt_q   <= '{default: '0};
        acc_q   <= '0;
        idx_q   <= '0;
        busy_q  <= 1'b0;
`ifdef RO_CNT_SAT_EN
        sat_q   <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '{default: '0};
            if (ro_en) begin
              state_q <= StCount;
            end
          end
          StCount: begin
            cnt_q <= cnt_nxt;
`ifdef RO_CNT_SAT_EN
            if (sat_hit) begin
              sat_q <= 1'b1;
            end
`endif
            if (valid_in) begin
              state_q <= StSum;
              busy_q  <= 1'b1;
              idx_q   <= '0;
              acc_q   <= '0;
            end
          end
          StSum: begin
            acc_q <= acc_sum;
            if (idx_q == LastIdx) begin
              // Final sum lands in acc_q; the output load happens next cycle.
              load_q  <= 1'b1;
              busy_q  <= 1'b0;
              idx_q   <= '0;
              cnt_q   <= '{default: '0};
              state_q <= ro_en ? StCount : StIdle;
`ifdef RO_CNT_SAT_EN
              sat_q   <= 1'b0;
`endif
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ro_sample_counter.sv
// Self-checking bench for ro_sample_counter: vector table, random windows vs. edge-count model,
// and hand-written corner sequences. A second CNT_W=4 instance covers counter overflow.
module tb_ro_sample_counter;

  localparam int unsigned NumRo = 4;
  localparam int unsigned SumW  = 18;
  localparam int unsigned SumWS = 6;

  typedef int unsigned cnt4_t [4];
  typedef struct {
    cnt4_t       e;
    int unsigned exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, ro_rst, ro_en, valid_in, sample_ready;
  logic [NumRo-1:0]  ro_in;
  logic [SumW-1:0]   sample_data;
  logic              sample_valid, overrun, busy;
  logic [SumWS-1:0]  sample_data_s;
  logic              sample_valid_s, overrun_s, busy_s;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  ro_sample_counter #(.NUM_RO(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ro_rst(ro_rst), .ro_en(ro_en), .valid_in(valid_in), .ro_in(ro_in),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .busy(busy)
  );

  ro_sample_counter #(.NUM_RO(4), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .ro_rst(ro_rst), .ro_en(ro_en), .valid_in(valid_in), .ro_in(ro_in),
    .sample_data(sample_data_s), .sample_valid(sample_valid_s), .sample_ready(sample_ready),
    .overrun(overrun_s), .busy(busy_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each RO i gives c[i] rising edges, 4 clk high / 4 clk low.
  task automatic pulse_edges(input cnt4_t c);
    int unsigned mx = 0;
    logic [NumRo-1:0] mask;
    for (int i = 0; i < 4; i++) if (c[i] > mx) mx = c[i];
    for (int unsigned k = 0; k < mx; k++) begin
      for (int i = 0; i < 4; i++) mask[i] = (k < c[i]);
      ro_in = mask;
      repeat (4) tick();
      ro_in = '0;
      repeat (4) tick();
    end
  endtask

  task automatic close_window();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_sample(input string name);
    int unsigned n = 0;
    while (!sample_valid && n < 60) begin
      tick();
      n++;
    end
    check({name, " valid"}, 32'(sample_valid), 32'd1);
  endtask

  task automatic consume(input string name);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    check({name, " drop"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [5];
    cnt4_t       c;
    int unsigned exp_sum, lat, busy_cnt, seen;

    tbl[0].e = '{3, 5, 7, 9};  tbl[0].exp = 24;
    tbl[1].e = '{1, 1, 1, 1};  tbl[1].exp = 4;
    tbl[2].e = '{0, 0, 0, 0};  tbl[2].exp = 0;
    tbl[3].e = '{2, 0, 4, 1};  tbl[3].exp = 7;
    tbl[4].e = '{0, 12, 0, 3}; tbl[4].exp = 15;

    rst = 1'b1; ro_rst = 1'b0; ro_en = 1'b0; valid_in = 1'b0; sample_ready = 1'b0; ro_in = '0;
    repeat (2) tick();
    check("reset data", 32'(sample_data), 32'd0);
    check("reset valid", 32'(sample_valid), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ro_en = 1'b1;
    repeat (2) tick();

    // Basic window: latency and busy length.
    pulse_edges('{10, 0, 0, 0});
    close_window();
    busy_cnt = 32'(busy);
    lat = 0;
    while (!sample_valid && lat < 20) begin
      tick();
      lat++;
      busy_cnt += 32'(busy);
    end
    check("basic latency", lat, 32'd5);
    check("basic busy cycles", busy_cnt, 32'd4);
    check("basic data", 32'(sample_data), 32'd10);
    repeat (3) tick();
    check("basic hold valid", 32'(sample_valid), 32'd1);
    check("basic hold data", 32'(sample_data), 32'd10);
    consume("basic");

    for (int i = 0; i < 5; i++) begin
      pulse_edges(tbl[i].e);
      close_window();
      wait_sample($sformatf("table%0d", i));
      check($sformatf("table%0d data", i), 32'(sample_data), tbl[i].exp);
      consume($sformatf("table%0d", i));
    end

    // Random windows; edges made while ro_en=0 must not count.
    for (int w = 0; w < 6; w++) begin
      exp_sum = 0;
      for (int i = 0; i < 4; i++) begin
        c[i] = $urandom_range(20);
        exp_sum += c[i];
      end
      if ($urandom_range(1) == 1) begin
        cnt4_t junk;
        ro_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) junk[i] = $urandom_range(3);
        pulse_edges(junk);
        ro_en = 1'b1;
        tick();
      end
      pulse_edges(c);
      close_window();
      wait_sample($sformatf("rand%0d", w));
      repeat ($urandom_range(4)) tick();
      check($sformatf("rand%0d data", w), 32'(sample_data), exp_sum);
      consume($sformatf("rand%0d", w));
    end

    // Backpressure and overrun.
    pulse_edges('{10, 0, 0, 0});
    close_window();
    wait_sample("bp1");
    pulse_edges('{20, 0, 0, 0});
    close_window();
    repeat (8) tick();
    check("bp data kept", 32'(sample_data), 32'd10);
    check("bp overrun", 32'(overrun), 32'd1);
    check("bp valid", 32'(sample_valid), 32'd1);
    consume("bp");
    check("bp overrun sticky", 32'(overrun), 32'd1);

    // ro_rst beats valid_in.
    pulse_edges('{6, 0, 0, 0});
    ro_rst = 1'b1;
    valid_in = 1'b1;
    tick();
    ro_rst = 1'b0;
    valid_in = 1'b0;
    check("rorst busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (12) begin
      tick();
      seen |= 32'(sample_valid);
    end
    check("rorst no sample", seen, 32'd0);
    pulse_edges('{2, 0, 0, 0});
    close_window();
    wait_sample("rorst next");
    check("rorst next data", 32'(sample_data), 32'd2);
    consume("rorst next");

    // valid_in in IDLE is ignored and IDLE does not count.
    ro_en = 1'b0;
    ro_rst = 1'b1;
    tick();
    ro_rst = 1'b0;
    pulse_edges('{3, 3, 0, 0});
    close_window();
    seen = 0;
    repeat (10) begin
      tick();
      seen |= 32'(sample_valid) | 32'(busy);
    end
    check("idle ignores valid_in", seen, 32'd0);
    ro_en = 1'b1;
    repeat (2) tick();
    pulse_edges('{0, 0, 1, 0});
    close_window();
    wait_sample("idle next");
    check("idle next data", 32'(sample_data), 32'd1);
    consume("idle next");

    // Overflow: 18 edges into a 4-bit counter.
    pulse_edges('{18, 0, 0, 0});
    close_window();
    wait_sample("ovf");
    check("ovf wide data", 32'(sample_data), 32'd18);
    check("ovf narrow valid", 32'(sample_valid_s), 32'd1);
`ifdef RO_CNT_SAT_EN
    check("ovf narrow data", 32'(sample_data_s), 32'd63);
`else
    check("ovf narrow data", 32'(sample_data_s), 32'd2);
`endif

    // rst in the second SUM cycle, with a sample still pending.
    pulse_edges('{0, 5, 0, 0});
    close_window();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midsum data", 32'(sample_data), 32'd0);
    check("midsum valid", 32'(sample_valid), 32'd0);
    check("midsum overrun", 32'(overrun), 32'd0);
    check("midsum busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (10) begin
      tick();
      seen |= 32'(sample_valid);
    end
    check("midsum no sample", seen, 32'd0);
    pulse_edges('{4, 0, 0, 0});
    close_window();
    wait_sample("after rst");
    check("after rst data", 32'(sample_data), 32'd4);
    consume("after rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
